// File: rtl/ram_clearable.sv
// Parametrised single-port synchronous RAM with a registered read port and a
// zero-fill sequencer that runs after reset and whenever clear is accepted.
module ram_clearable #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    input  logic              rd_en,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clrAddr_q, clrAddr_d;
    logic              outValid_q, outValid_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  out_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [WIDTH-1:0]  memData;
    logic              rdAccept;

    // Next-state and memory-port steering; the sequencer owns the write port in CLEAR.
    always_comb begin
        state_d    = state_q;
        clrAddr_d  = clrAddr_q;
        outValid_d = 1'b0;
        busy_d     = busy_q;
        memWe      = 1'b0;
        memAddr    = address;
        memData    = in;
        rdAccept   = 1'b0;

        if (reset) begin
            state_d   = CLEAR;
            clrAddr_d = '0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    memWe     = 1'b1;
                    memAddr   = clrAddr_q;
                    memData   = '0;
                    clrAddr_d = clrAddr_q + 1'b1;
                    if (clrAddr_q == LAST_ADDR) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        busy_d  = 1'b1;
                    end
                end
                IDLE: begin
                    busy_d = 1'b0;
                    // clear wins over any simultaneous access
                    if (clear) begin
                        state_d   = CLEAR;
                        clrAddr_d = '0;
                        busy_d    = 1'b1;
                    end else begin
                        memWe      = load;
                        rdAccept   = rd_en;
                        outValid_d = rd_en;
                    end
                end
                default: begin
                    state_d   = CLEAR;
                    clrAddr_d = '0;
                    busy_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        clrAddr_q  <= clrAddr_d;
        outValid_q <= outValid_d;
        busy_q     <= busy_d;
    end

    // Storage and read register; the read samples the pre-write word (read-first).
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem_q[memAddr] <= memData;
        end
        if (reset) begin
            out_q <= '0;
        end else if (rdAccept) begin
            out_q <= mem_q[address];
        end
    end

    assign out       = out_q;
    assign out_valid = outValid_q;
    assign busy      = busy_q;

    busyMatchesState: assert property (@(posedge clk) disable iff (reset)
        busy_q == (state_q == CLEAR));

    noValidWhileBusy: assert property (@(posedge clk) disable iff (reset)
        outValid_q |-> !busy_q);

endmodule

// File: tb/tb_ram_clearable.sv
// Scoreboard bench for ram_clearable: a default 16x512 instance under directed
// and random traffic, plus an 8x16 instance for the small-geometry case.
module tb_ram_clearable;

    localparam int W      = 16;
    localparam int AW     = 9;
    localparam int DEPTH  = 512;
    localparam int SW     = 8;
    localparam int SAW    = 4;
    localparam int SDEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, load, rdEn, clear, outValid, busy;
    logic [W-1:0]  in, out;
    logic [AW-1:0] address;

    logic           sReset, sLoad, sRdEn, sClear, sOutValid, sBusy;
    logic [SW-1:0]  sIn, sOut;
    logic [SAW-1:0] sAddress;

    int checks   = 0;
    int failures = 0;

    ram_clearable #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .in(in), .address(address), .load(load),
        .rd_en(rdEn), .clear(clear), .out(out), .out_valid(outValid), .busy(busy)
    );

    ram_clearable #(.WIDTH(SW), .ADDR_W(SAW)) dutSmall (
        .clk(clk), .reset(sReset), .in(sIn), .address(sAddress), .load(sLoad),
        .rd_en(sRdEn), .clear(sClear), .out(sOut), .out_valid(sOutValid), .busy(sBusy)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: a clear (or reset) empties the array at once and makes the
    // block deaf for DEPTH edges; otherwise reads see the old word, then writes land.
    typedef struct { int cyc; logic [W-1:0] data; } exp_t;
    exp_t         expQ[$];
    logic [W-1:0] refMem [DEPTH];
    int           remaining = 0;
    int           cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            remaining = DEPTH;
            foreach (refMem[i]) refMem[i] = '0;
        end else if (remaining > 0) begin
            remaining--;
        end else if (clear) begin
            remaining = DEPTH;
            foreach (refMem[i]) refMem[i] = '0;
        end else begin
            if (rdEn) expQ.push_back(exp_t'{cyc, refMem[address]});
            if (load) refMem[address] = in;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        checkOutput("busy", 32'(busy), 32'(remaining > 0));
        if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
            e = expQ.pop_front();
            checkOutput("readValid", 32'(outValid), 32'd1);
            checkOutput("readData", 32'(out), 32'(e.data));
        end else begin
            checkOutput("spuriousValid", 32'(outValid), 32'd0);
        end
    end

    typedef struct { int cyc; logic [SW-1:0] data; } sexp_t;
    sexp_t         sExpQ[$];
    logic [SW-1:0] sRefMem [SDEPTH];
    int            sRemaining = 0;
    int            sCyc = 0;

    always @(posedge clk) begin
        sCyc++;
        if (sReset) begin
            sRemaining = SDEPTH;
            foreach (sRefMem[i]) sRefMem[i] = '0;
        end else if (sRemaining > 0) begin
            sRemaining--;
        end else if (sClear) begin
            sRemaining = SDEPTH;
            foreach (sRefMem[i]) sRefMem[i] = '0;
        end else begin
            if (sRdEn) sExpQ.push_back(sexp_t'{sCyc, sRefMem[sAddress]});
            if (sLoad) sRefMem[sAddress] = sIn;
        end
    end

    always @(negedge clk) begin
        sexp_t e;
        checkOutput("smallBusy", 32'(sBusy), 32'(sRemaining > 0));
        if (sExpQ.size() > 0 && sExpQ[0].cyc == sCyc) begin
            e = sExpQ.pop_front();
            checkOutput("smallReadValid", 32'(sOutValid), 32'd1);
            checkOutput("smallReadData", 32'(sOut), 32'(e.data));
        end else begin
            checkOutput("smallSpuriousValid", 32'(sOutValid), 32'd0);
        end
    end

    task automatic applyStimulus(input logic ld, input logic rd, input logic clr,
                                 input logic [AW-1:0] a, input logic [W-1:0] d);
        load    = ld;
        rdEn    = rd;
        clear   = clr;
        address = a;
        in      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic applySmall(input logic ld, input logic rd, input logic clr,
                              input logic [SAW-1:0] a, input logic [SW-1:0] d);
        sLoad    = ld;
        sRdEn    = rd;
        sClear   = clr;
        sAddress = a;
        sIn      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic countBusy(input string name, input int want);
        int n = 0;
        while (busy && n < 2000) begin
            applyStimulus(1'($urandom % 2), 1'($urandom % 2), 1'b0,
                          AW'($urandom), W'($urandom));
            n++;
        end
        checkOutput(name, 32'(n), 32'(want));
    endtask

    initial begin
        int n;
        logic [AW-1:0] a;

        reset = 1'b1; load = 1'b0; rdEn = 1'b0; clear = 1'b0; address = '0; in = '0;
        sReset = 1'b1; sLoad = 1'b0; sRdEn = 1'b0; sClear = 1'b0; sAddress = '0; sIn = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Power-up fill, then reads of the corners and middle.
        n = 0;
        while (busy && n < 2000) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
            n++;
        end
        checkOutput("busyAfterReset", 32'(n), 32'd512);
        applyStimulus(1'b0, 1'b1, 1'b0, 9'd0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 9'd255, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 9'd511, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        // Write then read back, and out holds once valid drops.
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h1A5, 16'hBEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 9'h1A5, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("holdValid", 32'(outValid), 32'd0);
        checkOutput("holdOut", 32'(out), 32'h0000BEEF);

        // Simultaneous read and write to one address returns the old word.
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h010, 16'h1234);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'h010, 16'h5678);
        applyStimulus(1'b0, 1'b1, 1'b0, 9'h010, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        // Clear with traffic ignored while busy.
        applyStimulus(1'b1, 1'b0, 1'b0, 9'd0, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'd511, 16'hFFFF);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'd511, 16'h1111);
        countBusy("busyAfterClear", 512);
        applyStimulus(1'b0, 1'b1, 1'b0, 9'd0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 9'd511, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        // Reset landing in the middle of a clear restarts the full fill.
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h033, 16'hAAAA);
        applyStimulus(1'b0, 1'b1, 1'b0, 9'h033, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
        repeat (100) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 9'h033, '0);
        checkOutput("resetOut", 32'(out), 32'd0);
        checkOutput("resetValid", 32'(outValid), 32'd0);
        reset = 1'b0;
        countBusy("busyAfterMidReset", 512);

        // Random traffic biased toward a small window so reads revisit writes.
        for (int i = 0; i < 600; i++) begin
            a = ($urandom % 2) ? AW'($urandom % 16) : AW'($urandom);
            applyStimulus(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 250 == 0),
                          a, W'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        n = 0;
        while (busy && n < 2000) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
            n++;
        end
        checkOutput("randomDrain", 32'(busy), 32'd0);

        // Small geometry: 16-edge fill, full write/readback, no aliasing 15 onto 0.
        applySmall(1'b0, 1'b0, 1'b0, '0, '0);
        sReset = 1'b0;
        n = 0;
        while (sBusy && n < 200) begin
            applySmall(1'b0, 1'b0, 1'b0, '0, '0);
            n++;
        end
        checkOutput("smallBusyLen", 32'(n), 32'd16);
        for (int i = 0; i < SDEPTH; i++) applySmall(1'b1, 1'b0, 1'b0, SAW'(i), SW'(i) ^ 8'hA5);
        for (int i = 0; i < SDEPTH; i++) applySmall(1'b0, 1'b1, 1'b0, SAW'(i), '0);
        applySmall(1'b0, 1'b1, 1'b0, 4'd0, '0);
        applySmall(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("smallNoAlias", 32'(sOut), 32'h000000A5);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", 32'(expQ.size() + sExpQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_clearable.md
Name: ram_clearable

Overview:
- Parametrised single-port synchronous RAM, the successor to the fixed 16-bit x 512 memory block.
- Adds a registered read port with a valid flag, and a hardware zero-fill sequencer. The sequencer runs automatically after reset and on demand via `clear`.
- Serves as the data/screen memory building block for the CPU-on-FPGA memory subsystem. It guarantees defined contents, with no X, after reset.

Parameters:
- WIDTH, 16: data word width in bits.
- ADDR_W, 9: address width. Depth DEPTH = 2**ADDR_W words, exactly; no spare word.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  write data.
- address  input  ADDR_W  word address for both read and write.
- load  input  1  write enable; when high and not busy, memory[address] <= in.
- rd_en  input  1  read request; when high and not busy, data appears on `out` next cycle.
- clear  input  1  start zero-fill of the whole array. Sampled each edge; honoured only in IDLE.
- out  output  WIDTH  registered read data.
- out_valid  output  1  high for one cycle when `out` carries data for a read accepted on the previous edge.
- busy  output  1  high while the zero-fill sequencer owns the array.

Behaviour:
- Storage is DEPTH x WIDTH. Every address 0..DEPTH-1 is valid, and no address decoding wraps beyond DEPTH-1.
- States are CLEAR and IDLE. A clear counter `clr_addr` is ADDR_W bits wide.

Reset:
- Any edge with reset=1 forces state=CLEAR, clr_addr=0, out=0, out_valid=0, busy=1.
- No memory write occurs on a reset edge.
- Reset asserted mid-clear or mid-read restarts the sequence from address 0.

CLEAR state:
- Each edge writes memory[clr_addr] <= 0 and increments clr_addr.
- The edge that writes DEPTH-1 moves to IDLE, and busy=0 from that edge on.
- Consequently busy stays high for exactly DEPTH edges after reset release or clear acceptance.
- load, rd_en and clear are ignored; out holds its value and out_valid=0.

IDLE state:
- busy=0.
- load=1: memory[address] <= in at the edge.
- rd_en=1: out <= memory[address] at the edge, and out_valid=1 for the following cycle. Read latency is 1 cycle.
- rd_en=0: out holds its last value and out_valid=0.
- load=1 and rd_en=1 at the same address: read-first, so out gets the pre-write value and the new value is stored.
- clear=1: at that edge state->CLEAR and clr_addr=0, with zero-writes beginning the next edge.
- clear=1 together with load and/or rd_en: clear has priority; no write or read is performed, and out_valid=0.
- out_valid is never high in the cycle following a CLEAR-state edge.

Test Plan:
1. Release reset, hold rd_en=0 -> busy=1 for exactly 512 edges, then 0. Read of addresses 0, 255, 511 -> out=16'h0000 with out_valid=1 one cycle after each rd_en.
2. IDLE: load in=16'hBEEF at addr 9'h1A5, next cycle rd_en at 9'h1A5 -> out=16'hBEEF, out_valid=1 exactly one cycle later, then out_valid=0 with out held.
3. IDLE: addr 9'h010 holds 16'h1234; load=1, rd_en=1, in=16'h5678 same edge -> out=16'h1234. A subsequent read -> 16'h5678.
4. Write 16'hFFFF to addresses 0 and 511, pulse clear -> busy high 512 edges. load/rd_en during busy are ignored (out_valid stays 0), and afterwards both addresses read 16'h0000.
5. Assert reset at clear edge 100 (mid-clear), release -> busy restarts and is high for a full 512 edges; out=0 and out_valid=0 during reset.
6. Parameter sweep WIDTH=8, ADDR_W=4 -> busy lasts 16 edges. Write/readback of all 16 addresses with in=address^8'hA5 matches, and address 15 does not alias address 0.
